// File: rtl/sign_decisor_pipe.sv
// sign_decisor_pipe: per-lane result-sign decision for posit add/sub/mul/div,
// followed by a valid/ready register pipeline of STAGES beats.
//
// Optional feature macro: SIGN_ZERO_FIX_EN
//   defined   -> add/sub lanes whose magnitude result is exactly zero produce
//                a +0 sign (sign forced to 0 when res_zero is set).
//   undefined -> res_zero is accepted but ignored; sign follows the opcode rule.
//
// The sign is decided combinationally ahead of stage 1; each stage stores only
// LANES sign bits plus one valid bit. A stage advances whenever any stage at or
// after it is empty, or the consumer takes the output beat, so the pipeline
// sustains one beat per cycle and compresses bubbles under backpressure.

`ifndef N
`define N 16
`endif

module sign_decisor_pipe #(
  parameter int N       = `N,  // posit width, kept for codebase consistency
  parameter int LANES   = 4,   // independent sign lanes (1..16)
  parameter int STAGES  = 2,   // pipeline register depth (1..8)
  parameter int OP_SIZE = 2    // opcode width per lane
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           sign1,
  input  logic [LANES-1:0]           sign2,
  input  logic [LANES*OP_SIZE-1:0]   op,
  input  logic [LANES-1:0]           swap,
  input  logic [LANES-1:0]           res_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           sign,
  output logic                       busy
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  logic [LANES-1:0]  sign_next;
  logic [STAGES-1:0] stg_valid;
  logic [LANES-1:0]  stg_sign [STAGES];
  logic [STAGES-1:0] stg_adv;
  logic [STAGES-1:0] stg_load_valid;
  logic [LANES-1:0]  stg_load_sign [STAGES];
  logic              alive;

  // Width parameter and the unused opcode/flag bits are deliberately not part
  // of the datapath; they are gathered here so the intent is explicit.
  logic [31:0] unused_n;
  logic        unused_inputs;
  assign unused_n = 32'(N);
`ifdef SIGN_ZERO_FIX_EN
  assign unused_inputs = ^op;
`else
  assign unused_inputs = ^{op, res_zero};
`endif

  // Per-lane sign decision from opcode, operand signs and magnitude order.
  always_comb begin
    // NOTE: every variable written in this block gets a default first, so no
    // path through the loop/case can leave it unassigned and infer a latch.
    sign_next = '0;
    for (int i = 0; i < LANES; i++) begin
      op_e lane_op;
      lane_op = op_e'(op[i*OP_SIZE +: 2]);
      unique case (lane_op)
        OP_ADD:  sign_next[i] = swap[i] ? sign2[i]  : sign1[i];
        OP_SUB:  sign_next[i] = swap[i] ? ~sign2[i] : sign1[i];
        OP_MUL,
        OP_DIV:  sign_next[i] = sign1[i] ^ sign2[i];
        default: sign_next[i] = 1'b0;
      endcase
`ifdef SIGN_ZERO_FIX_EN
      // Exact cancellation in add/sub yields +0 rather than -0.
      if ((lane_op == OP_ADD || lane_op == OP_SUB) && res_zero[i]) begin
        sign_next[i] = 1'b0;
      end
`endif
    end
  end

  // Stage k may advance when it or any later stage is empty, or when the
  // consumer accepts the output beat (the whole chain then moves).
  always_comb begin
    logic hole;
    stg_adv = '0;
    hole    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      hole = 1'b0;
      for (int j = k; j < STAGES; j++) begin
        hole = hole | ~stg_valid[j];
      end
      stg_adv[k] = out_ready | hole;
    end
  end

  // What each stage would capture: the accepted input beat for stage 1,
  // the previous stage's contents for the rest.
  always_comb begin
    stg_load_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      stg_load_sign[k] = '0;
    end
    stg_load_valid[0] = in_valid & in_ready;
    stg_load_sign[0]  = sign_next;
    for (int k = 1; k < STAGES; k++) begin
      stg_load_valid[k] = stg_valid[k-1];
      stg_load_sign[k]  = stg_sign[k-1];
    end
  end

  // Comes out of reset low and rises on the first clock edge after release,
  // keeping in_ready low for the whole reset period.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Pipeline registers: advance per stage, data captured only with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      // NOTE: the sign registers are reset as well as the valid bits so that
      // sign reads 0 during and right after reset, not stale data.
      for (int k = 0; k < STAGES; k++) begin
        stg_sign[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stg_adv[k]) begin
          stg_valid[k] <= stg_load_valid[k];
          if (stg_load_valid[k]) begin
            stg_sign[k] <= stg_load_sign[k];
          end
        end
      end
    end
  end

  assign in_ready  = alive & stg_adv[0];
  assign out_valid = stg_valid[STAGES-1];
  assign sign      = stg_sign[STAGES-1];
  assign busy      = |stg_valid;

endmodule

// File: tb/tb_sign_decisor_pipe.sv
// Self-checking bench for sign_decisor_pipe (LANES=4, STAGES=2 main instance,
// plus a STAGES=1 instance for single-stage throughput/latency).
`timescale 1ns/1ps

module tb_sign_decisor_pipe;

  localparam int LANES = 4;
  localparam int STG   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, out_ready;
  logic             in_ready, out_valid, busy;
  logic [LANES-1:0] sign1, sign2, swap, res_zero, sign;
  logic [2*LANES-1:0] op;

  logic             in_valid1, out_ready1;
  logic             in_ready1, out_valid1, busy1;
  logic [LANES-1:0] sign_o1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [LANES-1:0] exp_q [$];

  always #5 clk = ~clk;

  sign_decisor_pipe #(.LANES(LANES), .STAGES(STG), .OP_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign1(sign1), .sign2(sign2), .op(op), .swap(swap), .res_zero(res_zero),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .busy(busy)
  );

  sign_decisor_pipe #(.LANES(LANES), .STAGES(1), .OP_SIZE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .sign1(sign1), .sign2(sign2), .op(op), .swap(swap), .res_zero(res_zero),
    .out_valid(out_valid1), .out_ready(out_ready1), .sign(sign_o1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: build concrete operands whose magnitudes respect swap, do the
  // arithmetic, and read the sign of the result.
  function automatic logic [LANES-1:0] ref_sign(input logic [2*LANES-1:0] o,
                                                input logic [LANES-1:0] s1,
                                                input logic [LANES-1:0] s2,
                                                input logic [LANES-1:0] sw,
                                                input logic [LANES-1:0] rz);
    logic [LANES-1:0] res;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      int m1, m2, a, b, r;
      logic [1:0] code;
      code = o[2*i +: 2];
      m1 = sw[i] ? 1 : 2;
      m2 = sw[i] ? 2 : 1;
      a  = s1[i] ? -m1 : m1;
      b  = s2[i] ? -m2 : m2;
      case (code)
        2'd0:    r = a + b;
        2'd1:    r = a - b;
        default: r = a * b;   // quotient sign equals product sign
      endcase
      res[i] = (r < 0);
`ifdef SIGN_ZERO_FIX_EN
      if (rz[i] && code[1] == 1'b0) res[i] = 1'b0;
`else
      if (rz[i]) res[i] = res[i];
`endif
    end
    return res;
  endfunction

  // Scoreboard and stall-hold monitor, sampled mid-cycle.
  logic             prev_stall = 1'b0;
  logic [LANES-1:0] prev_sign  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sign", 32'(sign), 32'(prev_sign));
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_sign(op, sign1, sign2, swap, res_zero));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_extra_beat", 32'd1, 32'd0);
        else check("sb_sign", 32'(sign), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_sign  = sign;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an empty pipeline and measure cycles until out_valid.
  task automatic send_one(input logic [7:0] o, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] sw, input logic [3:0] rz, output int lat);
    tick();
    op = o; sign1 = s1; sign2 = s2; swap = sw; res_zero = rz;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int accepted;
    int out_before;
    logic [3:0] e1, e_prev;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    op = '0; sign1 = '0; sign2 = '0; swap = '0; res_zero = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

    // Mul/div lanes, latency
    send_one(8'b10_10_11_11, 4'b0101, 4'b0011, 4'b0000, 4'b0000, lat);
    check("muldiv_latency", 32'(lat), 32'(STG));
    check("muldiv_sign", 32'(sign), 32'h6);

    // Add/sub with swap, mul on lane 3
    send_one(8'b10_01_01_00, 4'b1100, 4'b1011, 4'b0011, 4'b0000, lat);
    check("addsub_latency", 32'(lat), 32'(STG));
    check("addsub_sign", 32'(sign), 32'h5);

    // Exact-cancellation lanes
    send_one(8'b11_00_01_01, 4'b1110, 4'b0000, 4'b0000, 4'b1111, lat);
`ifdef SIGN_ZERO_FIX_EN
    e1 = 4'b1000;
`else
    e1 = 4'b1110;
`endif
    check("zero_sign", 32'(sign), 32'(e1));
    drain("directed");

    // 10 back-to-back beats, out_ready low for cycles 3..6
    out_before = n_out;
    accepted = 0;
    for (int c = 0; c < 60 && accepted < 10; c++) begin
      tick();
      op = 8'b10_10_10_10; sign1 = 4'(accepted); sign2 = 4'b0000;
      swap = 4'b0000; res_zero = 4'b0000;
      in_valid  = 1'b1;
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (c == 6) begin
        check("stall_in_ready_full", 32'(in_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      if (in_ready) accepted++;
    end
    check("burst_accepted", 32'(accepted), 32'd10);
    drain("burst");
    check("burst_out_count", 32'(n_out - out_before), 32'd10);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      tick();
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      op = 8'($urandom); sign1 = 4'($urandom); sign2 = 4'($urandom);
      swap = 4'($urandom); res_zero = 4'($urandom);
    end
    drain("random");

    // Reset with two beats in flight
    tick();
    out_ready = 1'b0; in_valid = 1'b1;
    op = 8'b10_10_10_10; sign1 = 4'b1111; sign2 = 4'b0000;
    tick();
    sign1 = 4'b1010;
    tick();
    in_valid = 1'b0;
    #2;
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_rel_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrst_rel_after_edge", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Single-stage instance: continuous streaming, latency 1
    e_prev = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      op = 8'($urandom); sign1 = 4'($urandom); sign2 = 4'($urandom);
      swap = 4'($urandom); res_zero = 4'($urandom);
      in_valid1 = 1'b1; out_ready1 = 1'b1;
      @(negedge clk);
      check("s1_in_ready", 32'(in_ready1), 32'd1);
      if (i == 0) begin
        check("s1_first_empty", 32'(out_valid1), 32'd0);
      end else begin
        check("s1_out_valid", 32'(out_valid1), 32'd1);
        check("s1_sign", 32'(sign_o1), 32'(e_prev));
      end
      e_prev = ref_sign(op, sign1, sign2, swap, res_zero);
    end
    tick();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("s1_last_out_valid", 32'(out_valid1), 32'd1);
    check("s1_last_sign", 32'(sign_o1), 32'(e_prev));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sign_decisor_pipe.md
SIGN_DECISOR_PIPE -- requirements
Module: sign_decisor_pipe

Interface
REQ-001 SHALL have parameter N, default `N, posit width carried for codebase consistency and not used in the sign datapath.
REQ-002 SHALL have parameter LANES, default 4, number of independent sign lanes (1..16).
REQ-003 SHALL have parameter STAGES, default 2, pipeline register depth (1..8).
REQ-004 SHALL have parameter OP_SIZE, default 2, opcode width per lane.
REQ-005 SHALL have ports: clk  input  1  single clock, all registers on rising edge.
REQ-006 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: in_valid  input  1  input beat valid.
REQ-008 SHALL have ports: in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have ports: sign1  input  LANES  per-lane sign of operand 1.
REQ-010 SHALL have ports: sign2  input  LANES  per-lane sign of operand 2.
REQ-011 SHALL have ports: op  input  LANES*OP_SIZE  per-lane opcode, lane i at bits [i*OP_SIZE +: OP_SIZE].
REQ-012 SHALL have ports: swap  input  LANES  per-lane flag, set when |operand2| > |operand1|.
REQ-013 SHALL have ports: res_zero  input  LANES  per-lane flag, set when the add/sub magnitude result is exactly zero.
REQ-014 SHALL have ports: out_valid  output  1  output beat valid.
REQ-015 SHALL have ports: out_ready  input  1  consumer accepts the beat.
REQ-016 SHALL have ports: sign  output  LANES  per-lane result sign.
REQ-017 SHALL have ports: busy  output  1  at least one pipeline stage holds a valid beat.

Function
REQ-018 SHALL decode opcodes as 00 add, 01 sub, 10 mul, 11 div.
REQ-019 SHALL compute each lane's sign as follows: add gives swap ? sign2 : sign1; sub gives swap ? ~sign2 : sign1; mul and div give sign1 ^ sign2.
REQ-020 SHALL compute all lanes independently, with no cross-lane interaction.
REQ-021 SHALL compute the sign combinationally before stage 1 and carry only the LANES result bits plus one valid bit per stage.
REQ-022 SHALL accept a beat only when in_valid && in_ready are both high on a rising edge.
REQ-023 SHALL complete a transfer only when out_valid && out_ready are both high on a rising edge.
REQ-024 SHALL have latency exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
REQ-025 SHALL advance each stage k when stage k+1 is empty or is itself advancing; the last stage advances on out_ready or when it is empty.
REQ-026 SHALL set in_ready = stage-1 empty || stage-1 advancing; in_ready depends combinationally on out_ready, and there is no combinational path from in_valid to out_valid.
REQ-027 SHALL sustain full throughput of one beat per cycle while out_ready is held high.
REQ-028 SHALL hold sign stable and keep out_valid high while out_valid && !out_ready; a valid beat SHALL NOT be dropped or duplicated.
REQ-029 SHALL accept a new beat in the same cycle a beat leaves when the pipeline is full and out_ready=1.
REQ-030 SHALL latch no data into a stage that holds no valid beat (bubble).
REQ-031 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-032 SHALL clear all stage valid bits and sign registers immediately when rst_n is asserted, independent of clk.
REQ-033 SHALL, during reset, hold out_valid=0, sign=0, busy=0 and in_ready=0.
REQ-034 SHALL discard in-flight beats on reset asserted mid-operation; none SHALL reappear afterwards.
REQ-035 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.

Configuration
REQ-036 SHALL, when macro SIGN_ZERO_FIX_EN is defined, force a lane's sign to 0 for add or sub whenever res_zero is set, so that +0 is produced on exact cancellation.
REQ-037 SHALL, when SIGN_ZERO_FIX_EN is undefined, keep the res_zero port present but ignore it, synthesise no gating logic for it, and follow REQ-019 only.

Verification
REQ-038 SHALL cover: LANES=4, STAGES=2, out_ready=1, op=10_10_11_11, sign1=0101, sign2=0011 -> sign=0110 exactly 2 cycles after acceptance.
REQ-039 SHALL cover: op=00 (add), swap=1, sign1=0, sign2=1 -> sign=1; op=01 (sub), swap=1, sign1=0, sign2=1 -> sign=0; op=01, swap=0, sign1=1 -> sign=1.
REQ-040 SHALL cover: op=01, sign1=0, sign2=0, swap=0, res_zero=1 with SIGN_ZERO_FIX_EN -> sign=0; with sign1=1 and SIGN_ZERO_FIX_EN -> 0; with sign1=1 without the macro -> 1.
REQ-041 SHALL cover: 10 back-to-back beats with out_ready low for cycles 3-6 -> all 10 beats out in order with no loss, out_valid and sign held stable while stalled, in_ready=0 once STAGES beats are held.
REQ-042 SHALL cover: rst_n asserted while 2 beats are in flight -> out_valid=0 and busy=0 immediately, no stale beat after release, in_ready=1 one edge later.
REQ-043 SHALL cover: STAGES=1 with continuous in_valid=1 and out_ready=1 -> one result per cycle, latency 1.
